// File: rtl/mem_access_ctrl.sv
// Single-request sequencer in front of data_memory: issues one read or write
// strobe per request, captures load data and returns a response.
//
// state    | meaning
// IDLE     | ready for a request
// ISSUE_RD | mem_read strobe high, address presented
// CAPTURE  | registered read data arrives from memory
// ISSUE_WR | mem_write strobe high, address and data presented
// RESP     | response held until rsp_ready
module mem_access_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int MEM_DEPTH = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_RD = 3'd1,
    CAPTURE  = 3'd2,
    ISSUE_WR = 3'd3,
    RESP     = 3'd4
  } state_t;

  // One extra bit so MEM_DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  state_t state;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_write   <= 1'b0;
      rsp_err     <= 1'b0;
      load_count  <= '0;
      store_count <= '0;
    end else begin
      // Strobes and memory bus are single-cycle pulses; default them low.
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_write <= req_write;
            if ({1'b0, req_addr} >= DEPTH) begin
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (req_write) begin
              mem_write <= 1'b1;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              state     <= ISSUE_WR;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= req_addr;
              state    <= ISSUE_RD;
            end
          end
        end
        ISSUE_RD: state <= CAPTURE;
        CAPTURE: begin
          rsp_data  <= mem_rdata;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        ISSUE_WR: begin
          rsp_data  <= mem_wdata;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            if (!rsp_err) begin
              if (rsp_write) begin
                if (store_count != '1) store_count <= store_count + 1'b1;
              end else begin
                if (load_count != '1) load_count <= load_count + 1'b1;
              end
            end
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
